dac_spi_scheduler: RTL
======================

// Module: dac_spi_scheduler
// PURPOSE
//  Sequences and shares the single DAC SPI serializer between the L/R audio sample stream and a low-rate config-word port.
//  Sits between the sample generator / control logic and the SPI serializer. Drives the serializer's o_DAC_Send / i_DAC_Ready handshake.
//  Sends an optional power-up init sequence. Counts dropped samples.
// PARAMETERS
//  SAMPLE_OFFSET   32'h21000    added to each raw sample (mod 2^32) before scaling
//  CHAN_A          8'b00110001  command/address byte prefixed to L word
//  CHAN_B          8'b00110010  command/address byte prefixed to R word
//  INIT_WORD_0     24'h280001   first init word (DAC reset)
//  INIT_WORD_1     24'h380001   second init word (internal reference on)
//  ACK_TIMEOUT     16           cycles allowed for i_DAC_Ready to fall after o_DAC_Send rises
//  CFG_MAX_DEFER   4            consecutive sample pairs a pending cfg word may be deferred
// PORTS
//  i_Clock          in   1   clock
//  i_Reset          in   1   synchronous, active-high reset
//  i_Sample_Valid   in   1   sample pair offered
//  i_Sample_L       in   32  left sample, raw
//  i_Sample_R       in   32  right sample, raw
//  o_Sample_Ready   out  1   sample slot empty; transfer on Valid&Ready
//  i_Cfg_Valid      in   1   config word offered
//  i_Cfg_Word       in   24  complete 24-bit DAC frame, sent verbatim
//  o_Cfg_Ready      out  1   cfg slot empty; transfer on Valid&Ready
//  o_DAC_Data       out  24  frame to serializer, stable while o_DAC_Send=1
//  o_DAC_Send       out  1   send request to serializer
//  i_DAC_Ready      in   1   serializer idle (falls when it accepts a frame)
//  o_Overrun_Count  out  8   dropped sample pairs, saturating at 255
//  o_Timeout        out  1   sticky: serializer failed to acknowledge
//  o_Busy           out  1   state != IDLE or any slot full
// BEHAVIOUR
//  Reset values:
//   - o_DAC_Send=0, o_DAC_Data=0, o_Overrun_Count=0, o_Timeout=0, o_Busy=1.
//   - o_Sample_Ready=0 and o_Cfg_Ready=0 while in INIT. Both are 1 in IDLE when their slots are empty.
//   - Reset mid-frame: o_DAC_Send=0 on the next cycle. Both slots are emptied. State returns to INIT (or IDLE if init is compiled out).
//  Sample slot:
//   - Holds one pair as L+SAMPLE_OFFSET and R+SAMPLE_OFFSET, registered on accept.
//   - Frames: L = {CHAN_A, L'[17:2]}, R = {CHAN_B, R'[17:2]}.
//   - i_Sample_Valid while the slot is full: pair dropped, o_Overrun_Count += 1 (holds at 8'hFF).
//  Cfg slot: one 24-bit word. No drop; producer must hold i_Cfg_Valid until Ready.
//  FSM states: INIT0, INIT1, IDLE, SEND, ACK_WAIT, DONE_WAIT.
//   - SEND: drive o_DAC_Data and o_DAC_Send=1, go to ACK_WAIT.
//   - ACK_WAIT: on i_DAC_Ready=0, o_DAC_Send=0, go to DONE_WAIT.
//     If ACK_TIMEOUT cycles elapse: o_DAC_Send=0, o_Timeout=1, drop the current frame (a pair is dropped whole), go to IDLE.
//   - DONE_WAIT: on i_DAC_Ready=1, go to the next frame or to IDLE.
//  Arbitration in IDLE (only when i_DAC_Ready=1):
//   - Sample pair beats cfg, unless cfg has waited CFG_MAX_DEFER pairs; then cfg goes first and the defer count clears.
//   - L and R are atomic: cfg is never inserted between them.
//   - Slot is freed when its last frame is acknowledged; the freed slot may accept on the same cycle.
//  Latency: accept at cycle N with FSM idle and serializer ready -> o_DAC_Send=1 with the L frame at N+2.
// CONFIGURATION
//  DAC_INIT_SEQ_EN:
//   - Defined: after reset the FSM sends INIT_WORD_0 then INIT_WORD_1 (full handshake each) before entering IDLE.
//     A timeout in INIT sets o_Timeout and skips to IDLE.
//   - Undefined: reset enters IDLE directly. INIT states and INIT_WORD_* are unused.
// STRUCTURE
//  Package dac_spi_pkg:
//   - FSM state enum, DAC_WORD_W=24, CHAN_W=8.
//   - Default channel/init constants.
//   - Frame-format function {chan, s[17:2]}.
//  Sub-module dac_sample_slot: one-pair buffer with offset add, full flag and saturating overrun counter.
//  Arbiter, FSM and timeout counter stay in this module.
// TESTING
//  1. Reset with DAC_INIT_SEQ_EN; serializer model ready -> frames 24'h280001 then 24'h380001, then o_Sample_Ready=1.
//  2. L=32'h0, R=32'h4 -> L frame {8'h31,16'h8400}, then R frame {8'h32,16'h8401}, with no gap frame between them.
//  3. Cfg 24'h123456 and a sample pair both pending in IDLE -> L, R, then 24'h123456.
//     With a continuous sample stream, cfg is sent after the 4th pair.
//  4. Three pairs offered while the slot is full -> o_Overrun_Count=3. Saturation test: 300 drops -> 8'hFF.
//  5. Serializer never lowers Ready -> o_DAC_Send falls after 16 cycles, o_Timeout=1, FSM is in IDLE.
//  6. i_Reset asserted during ACK_WAIT -> next cycle o_DAC_Send=0, count=0, both slots empty.

Source files
------------

// File: rtl/dac_spi_pkg.sv
// ----------------------------------------------------------------------------
// dac_spi_pkg
//   Shared types and constants for the DAC SPI scheduler.
//   - dac_state_e : scheduler FSM states
//   - dac_job_e   : which frame the FSM is currently carrying
//   - default channel command bytes, init words, sample offset and timing
//   - dac_frame() : builds a 24-bit DAC frame from a command byte and an
//                   offset-corrected sample
// ----------------------------------------------------------------------------
package dac_spi_pkg;

    localparam int DAC_WORD_W = 24;
    localparam int CHAN_W     = 8;
    localparam int SAMPLE_W   = 32;

    localparam logic [SAMPLE_W-1:0]   DEF_SAMPLE_OFFSET = 32'h0002_1000;
    localparam logic [CHAN_W-1:0]     DEF_CHAN_A        = 8'b0011_0001;
    localparam logic [CHAN_W-1:0]     DEF_CHAN_B        = 8'b0011_0010;
    localparam logic [DAC_WORD_W-1:0] DEF_INIT_WORD_0   = 24'h28_0001;
    localparam logic [DAC_WORD_W-1:0] DEF_INIT_WORD_1   = 24'h38_0001;
    localparam int                    DEF_ACK_TIMEOUT   = 16;
    localparam int                    DEF_CFG_MAX_DEFER = 4;

    typedef enum logic [2:0] {
        ST_INIT0     = 3'd0,
        ST_INIT1     = 3'd1,
        ST_IDLE      = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK_WAIT  = 3'd4,
        ST_DONE_WAIT = 3'd5
    } dac_state_e;

    typedef enum logic [2:0] {
        JOB_INIT0 = 3'd0,
        JOB_INIT1 = 3'd1,
        JOB_L     = 3'd2,
        JOB_R     = 3'd3,
        JOB_CFG   = 3'd4
    } dac_job_e;

    // The DAC takes 16 bits; bits [17:2] of the offset-corrected sample are
    // the ones that land in the frame, the rest are discarded.
    function automatic logic [DAC_WORD_W-1:0] dac_frame(
        input logic [CHAN_W-1:0]   chan,
        input logic [SAMPLE_W-1:0] s
    );
        logic unused_sample_bits;
        unused_sample_bits = ^{s[SAMPLE_W-1:18], s[1:0]};
        return {chan, s[17:2]};
    endfunction

endpackage

// File: rtl/dac_sample_slot.sv
// ----------------------------------------------------------------------------
// dac_sample_slot
//   One-pair holding buffer for the L/R sample stream. The offset is added
//   when the pair is accepted, so the stored values are already corrected.
//   A pair offered while the slot is full (and not being freed this cycle)
//   is dropped and counted in a counter that saturates at 8'hFF.
//
// Ports
//   clock_i, reset_i     clock, synchronous active-high reset
//   valid_i, l_i, r_i    offered sample pair (raw)
//   accept_en_i          slot may accept (low while the init sequence runs)
//   release_i            the pair's last frame finished; slot becomes free
//   ready_o              slot can take a pair this cycle
//   full_o               slot holds a pair
//   frame_l_o/frame_r_o  ready-made 24-bit L and R frames
//   overrun_o            dropped-pair count, saturating
// ----------------------------------------------------------------------------
module dac_sample_slot
    import dac_spi_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] SAMPLE_OFFSET = DEF_SAMPLE_OFFSET,
    parameter logic [CHAN_W-1:0]   CHAN_A        = DEF_CHAN_A,
    parameter logic [CHAN_W-1:0]   CHAN_B        = DEF_CHAN_B
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  valid_i,
    input  logic [SAMPLE_W-1:0]   l_i,
    input  logic [SAMPLE_W-1:0]   r_i,
    input  logic                  accept_en_i,
    input  logic                  release_i,
    output logic                  ready_o,
    output logic                  full_o,
    output logic [DAC_WORD_W-1:0] frame_l_o,
    output logic [DAC_WORD_W-1:0] frame_r_o,
    output logic [7:0]            overrun_o
);

    logic                full_q;
    logic                full_d;
    logic [SAMPLE_W-1:0] l_q;
    logic [SAMPLE_W-1:0] r_q;
    logic [7:0]          overrun_q;
    logic                accept;
    logic                drop;

    // A slot being freed this cycle can take the next pair immediately.
    assign ready_o = accept_en_i && (!full_q || release_i);
    assign accept  = valid_i && ready_o;
    assign drop    = valid_i && full_q && !release_i;

    always_comb begin
        full_d = full_q;
        if (accept) begin
            full_d = 1'b1;
        end else if (release_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            full_q    <= 1'b0;
            l_q       <= '0;
            r_q       <= '0;
            overrun_q <= 8'd0;
        end else begin
            full_q <= full_d;
            if (accept) begin
                l_q <= l_i + SAMPLE_OFFSET;
                r_q <= r_i + SAMPLE_OFFSET;
            end
            if (drop && (overrun_q != 8'hFF)) begin
                overrun_q <= overrun_q + 8'd1;
            end
        end
    end

    assign full_o    = full_q;
    assign frame_l_o = dac_frame(CHAN_A, l_q);
    assign frame_r_o = dac_frame(CHAN_B, r_q);
    assign overrun_o = overrun_q;

endmodule

// File: rtl/dac_spi_scheduler.sv
// ----------------------------------------------------------------------------
// dac_spi_scheduler
//   Shares the single DAC SPI serializer between the L/R sample stream and a
//   low-rate config-word port, optionally sending a power-up init sequence.
//
// Build option
//   DAC_INIT_SEQ_EN  when defined, INIT_WORD_0 then INIT_WORD_1 are sent after
//                    reset before the ports open; otherwise reset goes
//                    straight to IDLE.
//
// Handshakes
//   Producer side (sample, cfg): a word transfers on a rising clock edge where
//   Valid and Ready are both high. Ready never depends on Valid. The sample
//   port drops a pair offered while its slot is full; the cfg port never
//   drops, so its producer holds Valid until Ready.
//   Serializer side: o_DAC_Send rises with o_DAC_Data, both held until
//   i_DAC_Ready falls (frame taken); the next frame waits for i_DAC_Ready to
//   return high.
//
// Ports
//   i_Clock, i_Reset                       clock, synchronous active-high reset
//   i_Sample_Valid/_L/_R, o_Sample_Ready   raw sample pair input
//   i_Cfg_Valid, i_Cfg_Word, o_Cfg_Ready   verbatim 24-bit config frame input
//   o_DAC_Data, o_DAC_Send, i_DAC_Ready    serializer handshake
//   o_Overrun_Count                        dropped pairs, saturating at 255
//   o_Timeout                              sticky: serializer never acked
//   o_Busy                                 FSM active or a slot occupied
//   o_Dbg_State                            current FSM state (dac_state_e)
// ----------------------------------------------------------------------------
module dac_spi_scheduler
    import dac_spi_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0]   SAMPLE_OFFSET = DEF_SAMPLE_OFFSET,
    parameter logic [CHAN_W-1:0]     CHAN_A        = DEF_CHAN_A,
    parameter logic [CHAN_W-1:0]     CHAN_B        = DEF_CHAN_B,
    parameter int                    ACK_TIMEOUT   = DEF_ACK_TIMEOUT,
    parameter int                    CFG_MAX_DEFER = DEF_CFG_MAX_DEFER
`ifdef DAC_INIT_SEQ_EN
    ,
    parameter logic [DAC_WORD_W-1:0] INIT_WORD_0   = DEF_INIT_WORD_0,
    parameter logic [DAC_WORD_W-1:0] INIT_WORD_1   = DEF_INIT_WORD_1
`endif
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Sample_Valid,
    input  logic [SAMPLE_W-1:0]   i_Sample_L,
    input  logic [SAMPLE_W-1:0]   i_Sample_R,
    output logic                  o_Sample_Ready,
    input  logic                  i_Cfg_Valid,
    input  logic [DAC_WORD_W-1:0] i_Cfg_Word,
    output logic                  o_Cfg_Ready,
    output logic [DAC_WORD_W-1:0] o_DAC_Data,
    output logic                  o_DAC_Send,
    input  logic                  i_DAC_Ready,
    output logic [7:0]            o_Overrun_Count,
    output logic                  o_Timeout,
    output logic                  o_Busy,
    output logic [2:0]            o_Dbg_State
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam int DEF_W = $clog2(CFG_MAX_DEFER + 1);

`ifdef DAC_INIT_SEQ_EN
    localparam dac_state_e RESET_STATE = ST_INIT0;
    localparam logic       RESET_OPEN  = 1'b0;
`else
    localparam dac_state_e RESET_STATE = ST_IDLE;
    localparam logic       RESET_OPEN  = 1'b1;
`endif

    dac_state_e            state_q;
    dac_job_e              job_q;
    logic [DAC_WORD_W-1:0] data_q;
    logic                  send_q;
    logic                  timeout_q;
    logic                  busy_q;
    logic                  ports_open_q;
    logic [TMR_W-1:0]      timer_q;
    logic [DEF_W-1:0]      defer_q;

    logic                  cfg_full_q;
    logic                  cfg_full_d;
    logic [DAC_WORD_W-1:0] cfg_word_q;

    logic                  sample_full;
    logic [DAC_WORD_W-1:0] frame_l;
    logic [DAC_WORD_W-1:0] frame_r;

    logic                  frame_acked;
    logic                  frame_expired;
    logic                  frame_done;
    logic                  sample_release;
    logic                  cfg_release;
    logic                  cfg_accept;
    logic                  cfg_first;

    // A frame ends either with an acknowledge or with a timeout; both free
    // the slot the frame came from. A pair is freed after its R frame, or
    // as soon as either half times out, so no orphan R frame is ever sent.
    assign frame_acked    = (state_q == ST_ACK_WAIT) && !i_DAC_Ready;
    assign frame_expired  = (state_q == ST_ACK_WAIT) && i_DAC_Ready &&
                            (timer_q == TMR_W'(ACK_TIMEOUT - 1));
    assign frame_done     = frame_acked || frame_expired;
    assign sample_release = (frame_acked && (job_q == JOB_R)) ||
                            (frame_expired && ((job_q == JOB_L) || (job_q == JOB_R)));
    assign cfg_release    = frame_done && (job_q == JOB_CFG);

    // Cfg wins only after it has been passed over CFG_MAX_DEFER times, or
    // when there is no pair waiting.
    assign cfg_first = cfg_full_q &&
                       ((defer_q == DEF_W'(CFG_MAX_DEFER)) || !sample_full);

    dac_sample_slot #(
        .SAMPLE_OFFSET (SAMPLE_OFFSET),
        .CHAN_A        (CHAN_A),
        .CHAN_B        (CHAN_B)
    ) u_sample_slot (
        .clock_i     (i_Clock),
        .reset_i     (i_Reset),
        .valid_i     (i_Sample_Valid),
        .l_i         (i_Sample_L),
        .r_i         (i_Sample_R),
        .accept_en_i (ports_open_q),
        .release_i   (sample_release),
        .ready_o     (o_Sample_Ready),
        .full_o      (sample_full),
        .frame_l_o   (frame_l),
        .frame_r_o   (frame_r),
        .overrun_o   (o_Overrun_Count)
    );

    // ---------------------------------------------------------------- cfg slot
    assign o_Cfg_Ready = ports_open_q && (!cfg_full_q || cfg_release);
    assign cfg_accept  = i_Cfg_Valid && o_Cfg_Ready;

    always_comb begin
        cfg_full_d = cfg_full_q;
        if (cfg_accept) begin
            cfg_full_d = 1'b1;
        end else if (cfg_release) begin
            cfg_full_d = 1'b0;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            cfg_full_q <= 1'b0;
            cfg_word_q <= '0;
        end else begin
            cfg_full_q <= cfg_full_d;
            if (cfg_accept) begin
                cfg_word_q <= i_Cfg_Word;
            end
        end
    end

    // --------------------------------------------------------------------- FSM
    // Every frame goes SEND -> ACK_WAIT -> DONE_WAIT; job_q remembers what
    // the frame was so DONE_WAIT knows where to go next.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q      <= RESET_STATE;
            job_q        <= JOB_L;
            data_q       <= '0;
            send_q       <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b1;
            ports_open_q <= RESET_OPEN;
            timer_q      <= '0;
            defer_q      <= '0;
        end else begin
            busy_q <= (state_q != ST_IDLE) || sample_full || cfg_full_q;

            case (state_q)
`ifdef DAC_INIT_SEQ_EN
                ST_INIT0: begin
                    if (i_DAC_Ready) begin
                        state_q <= ST_SEND;
                        job_q   <= JOB_INIT0;
                        data_q  <= INIT_WORD_0;
                        send_q  <= 1'b1;
                        timer_q <= '0;
                    end
                end

                ST_INIT1: begin
                    if (i_DAC_Ready) begin
                        state_q <= ST_SEND;
                        job_q   <= JOB_INIT1;
                        data_q  <= INIT_WORD_1;
                        send_q  <= 1'b1;
                        timer_q <= '0;
                    end
                end
`endif

                ST_IDLE: begin
                    if (i_DAC_Ready) begin
                        if (cfg_first) begin
                            state_q <= ST_SEND;
                            job_q   <= JOB_CFG;
                            data_q  <= cfg_word_q;
                            send_q  <= 1'b1;
                            timer_q <= '0;
                            defer_q <= '0;
                        end else if (sample_full) begin
                            state_q <= ST_SEND;
                            job_q   <= JOB_L;
                            data_q  <= frame_l;
                            send_q  <= 1'b1;
                            timer_q <= '0;
                            if (cfg_full_q) begin
                                defer_q <= defer_q + DEF_W'(1);
                            end
                        end
                    end
                end

                ST_SEND: begin
                    state_q <= ST_ACK_WAIT;
                    timer_q <= timer_q + TMR_W'(1);
                end

                ST_ACK_WAIT: begin
                    if (frame_acked) begin
                        send_q  <= 1'b0;
                        state_q <= ST_DONE_WAIT;
                    end else if (frame_expired) begin
                        // Frame abandoned; any remaining init words are
                        // skipped as well.
                        send_q       <= 1'b0;
                        timeout_q    <= 1'b1;
                        ports_open_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end

                ST_DONE_WAIT: begin
                    if (i_DAC_Ready) begin
                        case (job_q)
`ifdef DAC_INIT_SEQ_EN
                            JOB_INIT0: state_q <= ST_INIT1;
                            JOB_INIT1: begin
                                state_q      <= ST_IDLE;
                                ports_open_q <= 1'b1;
                            end
`endif
                            JOB_L: begin
                                // R follows L directly; nothing is arbitrated
                                // in between.
                                state_q <= ST_SEND;
                                job_q   <= JOB_R;
                                data_q  <= frame_r;
                                send_q  <= 1'b1;
                                timer_q <= '0;
                            end
                            default: state_q <= ST_IDLE;
                        endcase
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_DAC_Data  = data_q;
    assign o_DAC_Send  = send_q;
    assign o_Timeout   = timeout_q;
    assign o_Busy      = busy_q;
    assign o_Dbg_State = state_q;

endmodule
